// File: rtl/output_stage.sv
// Output stage: accumulates 4-lane result rows across depth passes into a 4-row tile buffer,
// writes the tile to OutputMemory on the last pass. Define OSTAGE_SAT_EN for saturating lane adds.
module output_stage #(
  parameter int LANES = 4,
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int AW    = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TILE_START,
  input  logic                ACC_EN,
  input  logic                LAST_PASS,
  input  logic [3:0]          ODST,
  input  logic                PS_VALID,
  input  logic [LANES*DW-1:0] PS_DATA,
  output logic                OM_WE,
  output logic [AW-1:0]       OM_ADDR,
  output logic [LANES*DW-1:0] OM_WDATA,
  input  logic                OM_READY,
  output logic                Tile_Done,
  output logic                BUSY,
  output logic                ERR
);

  localparam int RW = $clog2(ROWS);
  localparam int W  = LANES * DW;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic          acc_q, acc_d;
  logic          last_q, last_d;
  logic [3:0]    odst_q, odst_d;
  logic          err_q, err_d;
  logic [W-1:0]  buf_q [ROWS];
  logic          buf_we;
  logic [W-1:0]  buf_wdata;
  logic [W-1:0]  row_sum;

  function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef OSTAGE_SAT_EN
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    // Sign-extended sum disagreeing in its top two bits means the lane overflowed.
    if (s[DW] != s[DW-1])
      return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s[DW-1:0];
`else
    return a + b;
`endif
  endfunction

  always_comb begin
    for (int k = 0; k < LANES; k++)
      row_sum[k*DW +: DW] = lane_add(buf_q[row_q][k*DW +: DW], PS_DATA[k*DW +: DW]);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wrow_d    = wrow_q;
    acc_d     = acc_q;
    last_d    = last_q;
    odst_d    = odst_q;
    buf_we    = 1'b0;
    buf_wdata = PS_DATA;
    err_d     = err_q | (PS_VALID && state_q != S_COLLECT)
                      | (TILE_START && state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (TILE_START) begin
          acc_d   = ACC_EN;
          last_d  = LAST_PASS;
          odst_d  = ODST;
          row_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (PS_VALID) begin
          buf_we    = 1'b1;
          buf_wdata = acc_q ? row_sum : PS_DATA;
          row_d     = row_q + 1'b1;
          if (row_q == LAST_ROW)
            state_d = last_q ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        if (OM_READY) begin
          wrow_d = wrow_q + 1'b1;
          if (wrow_q == LAST_ROW) begin
            wrow_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      wrow_q  <= '0;
      acc_q   <= 1'b0;
      last_q  <= 1'b0;
      odst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wrow_q  <= wrow_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      odst_q  <= odst_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the buffer is reset on purpose: a fresh accumulate pass after RST must start from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < ROWS; r++) buf_q[r] <= '0;
    end else if (buf_we) begin
      buf_q[row_q] <= buf_wdata;
    end
  end

  assign OM_WE     = (state_q == S_WRITE);
  assign OM_ADDR   = OM_WE ? {odst_q, wrow_q} : '0;
  assign OM_WDATA  = OM_WE ? buf_q[wrow_q] : '0;
  assign Tile_Done = (state_q == S_DONE);
  assign BUSY      = (state_q != S_IDLE);
  assign ERR       = err_q;

endmodule

// File: tb/tb_output_stage.sv
// Scoreboard bench for output_stage: directed passes push expected memory writes into a queue,
// a negedge monitor pops and compares every accepted write and counts Tile_Done pulses.
module tb_output_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TILE_START = 1'b0;
  logic        ACC_EN = 1'b0;
  logic        LAST_PASS = 1'b0;
  logic [3:0]  ODST = '0;
  logic        PS_VALID = 1'b0;
  logic [63:0] PS_DATA = '0;
  logic        OM_WE;
  logic [5:0]  OM_ADDR;
  logic [63:0] OM_WDATA;
  logic        OM_READY = 1'b1;
  logic        Tile_Done;
  logic        BUSY;
  logic        ERR;

  output_stage dut (
    .CLK(CLK), .RST(RST), .TILE_START(TILE_START), .ACC_EN(ACC_EN), .LAST_PASS(LAST_PASS),
    .ODST(ODST), .PS_VALID(PS_VALID), .PS_DATA(PS_DATA), .OM_WE(OM_WE), .OM_ADDR(OM_ADDR),
    .OM_WDATA(OM_WDATA), .OM_READY(OM_READY), .Tile_Done(Tile_Done), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  done_cnt = 0;
  int  exp_done = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: every accepted write must match the head of the expected queue.
  always @(negedge CLK) begin
    if (Tile_Done) done_cnt++;
    if (OM_WE && OM_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(OM_ADDR), 64'h3F);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(OM_ADDR), 64'(e.addr));
        check("wr_data", OM_WDATA, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_pass(input logic acc, input logic last, input logic [3:0] odst);
    TILE_START = 1'b1; ACC_EN = acc; LAST_PASS = last; ODST = odst;
    tick();
    TILE_START = 1'b0;
  endtask

  task automatic send_rows(input logic [63:0] base, input logic [63:0] inc, input int n);
    for (int k = 0; k < n; k++) begin
      PS_VALID = 1'b1;
      PS_DATA  = base + inc * 64'(k);
      tick();
    end
    PS_VALID = 1'b0;
  endtask

  task automatic push_writes(input logic [3:0] odst, input logic [63:0] base, input logic [63:0] inc);
    for (int k = 0; k < 4; k++) begin
      wr_t e;
      e.addr = {odst, 2'(k)};
      e.data = base + inc * 64'(k);
      exp_q.push_back(e);
    end
  endtask

  // Called right after the edge that accepted the last row (lat0 = cycles already elapsed).
  task automatic wait_done(input string name, input int lat0, input int exp_lat);
    int lat;
    lat = lat0;
    while (!Tile_Done && lat < 40) begin
      tick();
      lat++;
    end
    check(name, 64'(lat), 64'(exp_lat));
    exp_done++;
    tick();
    check({name, "_pulse_end"}, {62'd0, Tile_Done, BUSY}, 64'd0);
  endtask

  localparam logic [63:0] L10 = 64'h0010_0010_0010_0010;
  localparam logic [63:0] OVA = 64'h7FF0_7FF0_8010_0005;
  localparam logic [63:0] OVB = 64'h0020_0020_FFE0_0003;
`ifdef OSTAGE_SAT_EN
  localparam logic [63:0] OVR = 64'h7FFF_7FFF_8000_0008;
`else
  localparam logic [63:0] OVR = 64'h8010_8010_7FF0_0008;
`endif

  initial begin
    tick();
    tick();
    check("reset_outputs", {OM_WE, OM_ADDR, Tile_Done, BUSY, ERR}, 64'd0);
    check("reset_wdata", OM_WDATA, 64'd0);
    RST = 1'b0;
    tick();

    // 1: single overwrite+write pass at ODST=5
    push_writes(4'd5, 64'h0001_0002_0003_0004, 64'd1);
    start_pass(1'b0, 1'b1, 4'd5);
    check("t1_busy", 64'(BUSY), 64'd1);
    send_rows(64'h0001_0002_0003_0004, 64'd1, 4);
    wait_done("t1_latency", 1, 5);

    // 2: overwrite pass then accumulate+write pass
    start_pass(1'b0, 1'b0, 4'd3);
    send_rows(L10, 64'd0, 4);
    wait_done("t2_p0_latency", 1, 1);
    push_writes(4'd3, 64'h0020_0020_0020_0020, 64'd0);
    start_pass(1'b1, 1'b1, 4'd3);
    send_rows(L10, 64'd0, 4);
    wait_done("t2_p1_latency", 1, 5);

    // 3: lane overflow, positive and negative
    start_pass(1'b0, 1'b0, 4'd7);
    send_rows(OVA, 64'd0, 4);
    wait_done("t3_p0_latency", 1, 1);
    push_writes(4'd7, OVR, 64'd0);
    start_pass(1'b1, 1'b1, 4'd7);
    send_rows(OVB, 64'd0, 4);
    wait_done("t3_p1_latency", 1, 5);

    // 4: OM_READY low for 3 cycles while wrow 1 is presented
    push_writes(4'd9, 64'h1111_2222_3333_4440, 64'd1);
    start_pass(1'b0, 1'b1, 4'd9);
    send_rows(64'h1111_2222_3333_4440, 64'd1, 4);
    tick();
    OM_READY = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("t4_hold_addr", {57'd0, OM_WE, OM_ADDR}, {57'd0, 1'b1, 6'd37});
      check("t4_hold_data", OM_WDATA, 64'h1111_2222_3333_4441);
      tick();
    end
    OM_READY = 1'b1;
    wait_done("t4_latency", 5, 8);

    // 5a: TILE_START during WRITE is ignored and flags ERR
    check("t5_err_clear", 64'(ERR), 64'd0);
    push_writes(4'd2, 64'h0100_0200_0300_0400, 64'd1);
    start_pass(1'b0, 1'b1, 4'd2);
    send_rows(64'h0100_0200_0300_0400, 64'd1, 4);
    TILE_START = 1'b1; ODST = 4'd15; LAST_PASS = 1'b0;
    tick();
    TILE_START = 1'b0;
    wait_done("t5a_latency", 2, 5);
    check("t5a_err", 64'(ERR), 64'd1);

    // 5b: start plus stray row together: start taken, row dropped, buffer persists
    push_writes(4'd2, 64'h0101_0201_0301_0401, 64'd1);
    PS_VALID = 1'b1; PS_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
    start_pass(1'b1, 1'b1, 4'd2);
    send_rows(64'h0001_0001_0001_0001, 64'd0, 4);
    wait_done("t5b_latency", 1, 5);
    check("t5b_err_sticky", 64'(ERR), 64'd1);

    // 6: reset after two rows aborts; buffer cleared for the following accumulate pass
    start_pass(1'b1, 1'b1, 4'd4);
    send_rows(64'h5555_5555_5555_5555, 64'd0, 2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_after_rst", {OM_WE, Tile_Done, BUSY, ERR}, 64'd0);
    tick();
    check("t6_no_done", {62'd0, Tile_Done, BUSY}, 64'd0);
    push_writes(4'd4, 64'h0000_0000_0000_0010, 64'd1);
    start_pass(1'b1, 1'b1, 4'd4);
    send_rows(64'h0000_0000_0000_0010, 64'd1, 4);
    wait_done("t6_latency", 1, 5);

    // 5c: lone PS_VALID in IDLE sets ERR, which then stays set
    check("t5c_err_clear", 64'(ERR), 64'd0);
    PS_VALID = 1'b1; PS_DATA = 64'hDEAD_BEEF_0000_0001;
    tick();
    PS_VALID = 1'b0;
    check("t5c_err_set", {62'd0, ERR, BUSY}, 64'd2);
    tick();
    tick();
    check("t5c_err_sticky", 64'(ERR), 64'd1);

    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    check("tile_done_count", 64'(done_cnt), 64'(exp_done));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
